// File: rtl/param_split_router.sv
// Parametrised 1-to-NUM_PORTS token router with an independent FIFO per output port.
// Supports unicast, broadcast (all-or-nothing) and counted drops of out-of-range destinations.
module param_split_router #(
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int DEPTH     = 2,
  parameter int BCAST_EN  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [WIDTH-1:0]           i_in_data,
  input  logic [ADDR_W-1:0]          i_in_dest,
  input  logic                       i_in_bcast,
  output logic [NUM_PORTS-1:0]       o_out_valid,
  input  logic [NUM_PORTS-1:0]       i_out_ready,
  output logic [NUM_PORTS*WIDTH-1:0] o_out_data,
  output logic [15:0]                o_drop_cnt,
  output logic                       o_err_dest
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic                 w_bcast;
  logic                 w_accept;
  logic                 w_drop;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_push;
  logic [15:0]          r_dropCnt;
  logic                 r_errDest;

  // One-hot unicast select; an out-of-range destination selects no port at all.
  always_comb begin
    w_bcast = (BCAST_EN != 0) && i_in_bcast;
    w_sel   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sel[p] = !w_bcast && (i_in_dest == ADDR_W'(p));
    end
  end

  assign o_in_ready = w_bcast ? ~|w_full : ~|(w_sel & w_full);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_drop     = w_accept && !w_bcast && ~|w_sel;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;

    assign w_full[gp]      = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                             (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
    assign o_out_valid[gp] = (r_wrPtr != r_rdPtr);
    assign w_pop           = o_out_valid[gp] && i_out_ready[gp];
    assign w_push[gp]      = w_accept && (w_bcast || w_sel[gp]);

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_push[gp]) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_pop)      r_rdPtr <= r_rdPtr + 1'b1;
      end
    end

    // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
    always_ff @(posedge i_clk) begin
      if (w_push[gp]) r_mem[r_wrPtr[IDX_W-1:0]] <= i_in_data;
    end

    assign o_out_data[gp*WIDTH +: WIDTH] = o_out_valid[gp] ? r_mem[r_rdPtr[IDX_W-1:0]] : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dropCnt <= '0;
      r_errDest <= 1'b0;
    end else begin
      r_errDest <= w_drop;
      if (w_drop && (r_dropCnt != 16'hFFFF)) r_dropCnt <= r_dropCnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_dropCnt;
  assign o_err_dest = r_errDest;

endmodule

// File: tb/tb_param_split_router.sv
// Testbench for param_split_router: a 16-port instance checked against a per-port
// scoreboard, plus a 12-port instance for out-of-range drops and counter saturation.
module tb_param_split_router;

  logic clk;
  logic reset;

  logic        aInValid;
  logic        aInReady;
  logic [7:0]  aInData;
  logic [3:0]  aInDest;
  logic        aInBcast;
  logic [15:0] aOutValid;
  logic [15:0] aOutReady;
  logic [127:0] aOutData;
  logic [15:0] aDropCnt;
  logic        aErrDest;

  logic        bInValid;
  logic        bInReady;
  logic [7:0]  bInData;
  logic [3:0]  bInDest;
  logic        bInBcast;
  logic [11:0] bOutValid;
  logic [11:0] bOutReady;
  logic [95:0] bOutData;
  logic [15:0] bDropCnt;
  logic        bErrDest;

  int checks;
  int failures;
  logic aAccepted;
  logic [7:0] expQ [16][$];

  typedef struct {
    logic [3:0]  dest;
    logic [7:0]  data;
    logic        bcast;
    logic [15:0] outReady;
    logic        expReady;
  } vec_t;

  vec_t vecs [10];

  param_split_router #(.WIDTH(8), .NUM_PORTS(16), .DEPTH(2), .BCAST_EN(1)) dutA (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(aInValid), .o_in_ready(aInReady), .i_in_data(aInData),
    .i_in_dest(aInDest), .i_in_bcast(aInBcast),
    .o_out_valid(aOutValid), .i_out_ready(aOutReady), .o_out_data(aOutData),
    .o_drop_cnt(aDropCnt), .o_err_dest(aErrDest)
  );

  param_split_router #(.WIDTH(8), .NUM_PORTS(12), .ADDR_W(4), .DEPTH(2), .BCAST_EN(1)) dutB (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(bInValid), .o_in_ready(bInReady), .i_in_data(bInData),
    .i_in_dest(bInDest), .i_in_bcast(bInBcast),
    .o_out_valid(bOutValid), .i_out_ready(bOutReady), .o_out_data(bOutData),
    .o_drop_cnt(bDropCnt), .o_err_dest(bErrDest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Sample just before the rising edge: compare every port against the model, then
  // record any token the router accepts at the coming edge.
  task automatic applyStimulus();
    #3;
    aAccepted = aInValid && aInReady;
    for (int p = 0; p < 16; p++) begin
      checkOutput($sformatf("valid_p%0d", p), 32'(aOutValid[p]), 32'(expQ[p].size() != 0));
      if (aOutValid[p] && expQ[p].size() != 0) begin
        checkOutput($sformatf("data_p%0d", p), 32'(aOutData[p*8 +: 8]), 32'(expQ[p][0]));
        if (aOutReady[p]) void'(expQ[p].pop_front());
      end
    end
    if (aAccepted) begin
      if (aInBcast) begin
        for (int p = 0; p < 16; p++) expQ[p].push_back(aInData);
      end else begin
        expQ[aInDest].push_back(aInData);
      end
    end
  endtask

  task automatic finishCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleA(input int n);
    aInValid = 1'b0;
    aInBcast = 1'b0;
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      finishCycle();
    end
  endtask

  task automatic sendA(input string name, input logic [3:0] dest, input logic [7:0] data, input logic expReady);
    aInValid = 1'b1;
    aInDest  = dest;
    aInData  = data;
    aInBcast = 1'b0;
    applyStimulus();
    checkOutput(name, 32'(aInReady), 32'(expReady));
    finishCycle();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    aInValid  = 1'b0; aInData = '0; aInDest = '0; aInBcast = 1'b0; aOutReady = '1;
    bInValid  = 1'b0; bInData = '0; bInDest = '0; bInBcast = 1'b0; bOutReady = '1;

    vecs[0] = '{dest: 4'd0,  data: 8'h11, bcast: 1'b0, outReady: 16'hFFFF, expReady: 1'b1};
    vecs[1] = '{dest: 4'd15, data: 8'hFE, bcast: 1'b0, outReady: 16'hFFFF, expReady: 1'b1};
    vecs[2] = '{dest: 4'd9,  data: 8'h5A, bcast: 1'b1, outReady: 16'hFFFF, expReady: 1'b1};
    vecs[3] = '{dest: 4'd9,  data: 8'h66, bcast: 1'b0, outReady: 16'h0000, expReady: 1'b1};
    vecs[4] = '{dest: 4'd9,  data: 8'h67, bcast: 1'b0, outReady: 16'h0000, expReady: 1'b0};
    vecs[5] = '{dest: 4'd2,  data: 8'h71, bcast: 1'b0, outReady: 16'h0000, expReady: 1'b1};
    vecs[6] = '{dest: 4'd2,  data: 8'h72, bcast: 1'b1, outReady: 16'h0000, expReady: 1'b0};
    vecs[7] = '{dest: 4'd12, data: 8'h80, bcast: 1'b0, outReady: 16'hFFFF, expReady: 1'b1};
    vecs[8] = '{dest: 4'd3,  data: 8'h81, bcast: 1'b1, outReady: 16'hFFFF, expReady: 1'b1};
    vecs[9] = '{dest: 4'd6,  data: 8'h82, bcast: 1'b0, outReady: 16'h0040, expReady: 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_valid", 32'(aOutValid), 32'h0);
    checkOutput("rst_data_lo", aOutData[31:0], 32'h0);
    checkOutput("rst_drop", 32'(aDropCnt), 32'h0);
    checkOutput("rst_err", 32'(aErrDest), 32'h0);
    checkOutput("rst_drop_b", 32'(bDropCnt), 32'h0);
    @(negedge clk);

    // Single unicast to port 5 shows up one cycle later
    sendA("t1_ready", 4'd5, 8'hA3, 1'b1);
    aInValid = 1'b0;
    applyStimulus();
    checkOutput("t1_valid", 32'(aOutValid), 32'h0020);
    checkOutput("t1_data", 32'(aOutData[5*8 +: 8]), 32'hA3);
    checkOutput("t1_drop", 32'(aDropCnt), 32'h0);
    finishCycle();
    idleA(2);

    // Table of vectors: in_ready under varying fill levels and out_ready patterns
    for (int i = 0; i < 10; i++) begin
      aInValid  = 1'b1;
      aInDest   = vecs[i].dest;
      aInData   = vecs[i].data;
      aInBcast  = vecs[i].bcast;
      aOutReady = vecs[i].outReady;
      applyStimulus();
      checkOutput($sformatf("vec%0d_ready", i), 32'(aInReady), 32'(vecs[i].expReady));
      finishCycle();
    end
    aOutReady = '1;
    idleA(4);

    // Port 3 stalls while port 4 still flows; order kept once port 3 drains
    aOutReady = 16'hFFF7;
    sendA("t2_ready_d0", 4'd3, 8'hD0, 1'b1);
    sendA("t2_ready_d1", 4'd3, 8'hD1, 1'b1);
    sendA("t2_ready_full_a", 4'd3, 8'hD2, 1'b0);
    sendA("t2_ready_full_b", 4'd3, 8'hD2, 1'b0);
    sendA("t2_ready_p4", 4'd4, 8'hD3, 1'b1);
    aInValid = 1'b0;
    applyStimulus();
    checkOutput("t2_valid_p3_p4", 32'(aOutValid & 16'h0018), 32'h0018);
    finishCycle();
    aOutReady = '1;
    sendA("t2_no_passthru", 4'd3, 8'hD2, 1'b0);
    sendA("t2_ready_after_pop", 4'd3, 8'hD2, 1'b1);
    idleA(4);

    // Broadcast blocked by a full port 7, then delivered to every port
    aOutReady = 16'hFF7F;
    sendA("t4_fill_e1", 4'd7, 8'hE1, 1'b1);
    sendA("t4_fill_e2", 4'd7, 8'hE2, 1'b1);
    idleA(1);
    aInValid = 1'b1; aInBcast = 1'b1; aInData = 8'h5C; aInDest = 4'd2;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("t4_bcast_blocked", 32'(aInReady), 32'h0);
      checkOutput("t4_no_partial", 32'(aOutValid), 32'h0080);
      finishCycle();
    end
    aOutReady = '1;
    applyStimulus();
    checkOutput("t4_still_full", 32'(aInReady), 32'h0);
    finishCycle();
    applyStimulus();
    checkOutput("t4_bcast_ready", 32'(aInReady), 32'h1);
    finishCycle();
    aInValid = 1'b0; aInBcast = 1'b0;
    aOutReady = '0;
    applyStimulus();
    checkOutput("t4_all_valid", 32'(aOutValid), 32'hFFFF);
    for (int p = 0; p < 16; p++) checkOutput($sformatf("t4_data_p%0d", p), 32'(aOutData[p*8 +: 8]), 32'h5C);
    finishCycle();
    aOutReady = '1;
    idleA(4);

    // Random unicast/broadcast traffic with random backpressure, holding unaccepted tokens
    begin
      logic pending;
      pending = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        aOutReady = 16'($urandom);
        if (!pending) begin
          if ($urandom_range(0, 3) != 0) begin
            aInValid = 1'b1;
            aInDest  = 4'($urandom_range(0, 15));
            aInData  = 8'($urandom);
            aInBcast = ($urandom_range(0, 15) == 0);
          end else begin
            aInValid = 1'b0;
            aInBcast = 1'b0;
          end
        end
        applyStimulus();
        pending = aInValid && !aAccepted;
        finishCycle();
      end
    end
    aOutReady = '1;
    idleA(6);
    for (int p = 0; p < 16; p++) checkOutput($sformatf("t5_drained_p%0d", p), 32'(expQ[p].size()), 32'h0);

    // Out-of-range destination on the 12-port instance: dropped and counted
    bInValid = 1'b1; bInDest = 4'd13; bInData = 8'h33;
    #3;
    checkOutput("t3_ready_oob", 32'(bInReady), 32'h1);
    @(posedge clk); @(negedge clk);
    bInValid = 1'b0;
    #3;
    checkOutput("t3_err_pulse", 32'(bErrDest), 32'h1);
    checkOutput("t3_drop_one", 32'(bDropCnt), 32'h1);
    checkOutput("t3_no_valid", 32'(bOutValid), 32'h0);
    @(posedge clk); @(negedge clk);
    #3;
    checkOutput("t3_err_cleared", 32'(bErrDest), 32'h0);
    @(negedge clk);
    bInValid = 1'b1; bInDest = 4'd11; bInData = 8'h44;
    #3;
    checkOutput("t3_ready_p11", 32'(bInReady), 32'h1);
    @(posedge clk); @(negedge clk);
    bInValid = 1'b0;
    #3;
    checkOutput("t3_valid_p11", 32'(bOutValid), 32'h800);
    checkOutput("t3_data_p11", 32'(bOutData[11*8 +: 8]), 32'h44);
    checkOutput("t3_err_inrange", 32'(bErrDest), 32'h0);
    @(negedge clk);
    bInValid = 1'b1; bInDest = 4'd13;
    repeat (65533) @(negedge clk);
    bInValid = 1'b0;
    #3;
    checkOutput("t3_drop_fffe", 32'(bDropCnt), 32'hFFFE);
    @(negedge clk);
    bInValid = 1'b1; bInDest = 4'd14;
    repeat (6) @(negedge clk);
    bInValid = 1'b0;
    #3;
    checkOutput("t3_drop_sat", 32'(bDropCnt), 32'hFFFF);
    @(negedge clk);
    #3;
    checkOutput("t3_drop_hold", 32'(bDropCnt), 32'hFFFF);
    checkOutput("t3_err_end", 32'(bErrDest), 32'h0);
    @(negedge clk);

    // Reset with three ports holding data discards everything immediately
    aOutReady = '0;
    sendA("t6_fill_p1", 4'd1, 8'hB1, 1'b1);
    sendA("t6_fill_p2", 4'd2, 8'hB2, 1'b1);
    sendA("t6_fill_p9", 4'd9, 8'hB9, 1'b1);
    aInValid = 1'b0;
    #2;
    checkOutput("t6_pre_valid", 32'(aOutValid), 32'h0206);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(aOutValid), 32'h0);
    checkOutput("t6_rst_data", aOutData[79:48], 32'h0);
    checkOutput("t6_rst_drop_b", 32'(bDropCnt), 32'h0);
    for (int p = 0; p < 16; p++) expQ[p].delete();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    sendA("t6_ready_p0", 4'd0, 8'h77, 1'b1);
    aInValid = 1'b0;
    applyStimulus();
    checkOutput("t6_latency", 32'(aOutValid), 32'h0001);
    checkOutput("t6_data", 32'(aOutData[7:0]), 32'h77);
    finishCycle();
    aOutReady = '1;
    idleA(3);
    for (int p = 0; p < 16; p++) checkOutput($sformatf("t6_drained_p%0d", p), 32'(expQ[p].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
